mem_access_unit: RTL and testbench

Memory-access stage of the five-stage pipeline: reads the EX/MEM pipeline register outputs, performs SPARC load/store accesses over a valid/ready data-memory port, and forwards results toward the MEM/WB register. It aligns and sign-extends load data, generates big-endian byte enables for stores, and stalls upstream stages while an access is outstanding. Non-memory instructions pass through with one cycle of latency.

---
 rtl/mem_access_unit_if.sv | 25 ++
 rtl/mem_access_unit.sv | 249 ++++++++++++++++++++++++
 tb/tb_mem_access_unit.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_unit_if.sv
// Data-memory port of the memory-access stage: valid/ready request channel
// plus a read-data return channel. The stage drives through the master
// modport; the memory model or arbiter connects to the slave modport.
interface mem_access_unit_if #(
   parameter int DATA_W = 32
);
   logic                  dmem_req;
   logic                  dmem_ready;
   logic [DATA_W-1:0]     dmem_addr;
   logic                  dmem_we;
   logic [DATA_W/8-1:0]   dmem_be;
   logic [DATA_W-1:0]     dmem_wdata;
   logic                  dmem_rvalid;
   logic [DATA_W-1:0]     dmem_rdata;

   modport master (
      output dmem_req, dmem_addr, dmem_we, dmem_be, dmem_wdata,
      input  dmem_ready, dmem_rvalid, dmem_rdata
   );

   modport slave (
      input  dmem_req, dmem_addr, dmem_we, dmem_be, dmem_wdata,
      output dmem_ready, dmem_rvalid, dmem_rdata
   );
endinterface

// File: rtl/mem_access_unit.sv
// Memory-access stage of the five-stage SPARC pipeline. Decodes the EX/MEM
// register, runs big-endian load/store accesses over a valid/ready port,
// aligns/extends load data and stalls upstream while an access is in flight.
// Non-memory instructions pass through with one cycle of latency.
// Optional feature macro: MEM_ALIGN_TRAP_EN (misaligned accesses trap instead
// of having their low address bits forced to zero).
module mem_access_unit #(
   parameter int DATA_W = 32,
   parameter int REG_W  = 5
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [REG_W-1:0]  mem_regD_in,
   input  logic [DATA_W-1:0] mem_alures_in,
   input  logic [1:0]        mem_op_in,
   input  logic [5:0]        mem_op3_in,
   input  logic [DATA_W-1:0] mem_stdata_in,
   output logic              mem_stall,
   mem_access_unit_if.master dmem,
   output logic              wb_valid,
   output logic              wb_en,
   output logic [REG_W-1:0]  wb_regD,
   output logic [DATA_W-1:0] wb_data,
   output logic              mem_trap
);

   typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, WAIT = 2'd2} state_t;

   localparam logic [REG_W-1:0] CALL_REG = 5'd15;

   function automatic logic is_load_f(input logic [5:0] op3);
      case (op3)
         6'b000000, 6'b000001, 6'b000010, 6'b001001, 6'b001010: is_load_f = 1'b1;
         default: is_load_f = 1'b0;
      endcase
   endfunction

   function automatic logic is_store_f(input logic [5:0] op3);
      case (op3)
         6'b000100, 6'b000101, 6'b000110: is_store_f = 1'b1;
         default: is_store_f = 1'b0;
      endcase
   endfunction

   // op3[1:0] encodes the access size: 00 word, 01 byte, 10 halfword.
   function automatic logic [3:0] lane_be_f(input logic [5:0] op3, input logic [1:0] off);
      case (op3[1:0])
         2'b01:   lane_be_f = 4'b1000 >> off;
         2'b10:   lane_be_f = off[1] ? 4'b0011 : 4'b1100;
         default: lane_be_f = 4'b1111;
      endcase
   endfunction

   function automatic logic [DATA_W-1:0] lane_wdata_f(input logic [5:0] op3,
                                                      input logic [DATA_W-1:0] data);
      case (op3[1:0])
         2'b01:   lane_wdata_f = {4{data[7:0]}};
         2'b10:   lane_wdata_f = {2{data[15:0]}};
         default: lane_wdata_f = data;
      endcase
   endfunction

   // Offset 0 is the most significant byte/halfword; op3[3] selects sign extension.
   function automatic logic [DATA_W-1:0] load_extract_f(input logic [5:0] op3,
                                                        input logic [1:0] off,
                                                        input logic [DATA_W-1:0] rdata);
      logic [7:0]  b;
      logic [15:0] h;
      b = rdata[(5'd24 - {off, 3'b000}) +: 8];
      h = off[1] ? rdata[15:0] : rdata[31:16];
      case (op3[1:0])
         2'b01:   load_extract_f = op3[3] ? {{(DATA_W-8){b[7]}}, b} : {{(DATA_W-8){1'b0}}, b};
         2'b10:   load_extract_f = op3[3] ? {{(DATA_W-16){h[15]}}, h} : {{(DATA_W-16){1'b0}}, h};
         default: load_extract_f = rdata;
      endcase
   endfunction

   state_t              state_r, state_s;
   logic                stall_r, req_r;
   logic                we_r, we_s;
   logic [3:0]          be_r, be_s;
   logic [DATA_W-1:0]   addr_r, addr_s;
   logic [DATA_W-1:0]   wdata_r, wdata_s;
   logic [5:0]          op3_r, op3_s;
   logic [1:0]          off_r, off_s;
   logic [REG_W-1:0]    regd_r, regd_s;
   logic                wb_valid_r, wb_valid_s;
   logic                wb_en_r, wb_en_s;
   logic [REG_W-1:0]    wb_regd_r, wb_regd_s;
   logic [DATA_W-1:0]   wb_data_r, wb_data_s;
   logic                mem_access_s;
   logic [1:0]          off_align_s;
`ifdef MEM_ALIGN_TRAP_EN
   logic                trap_r, trap_s;
   logic                misalign_s;
`endif

   assign mem_access_s = (mem_op_in == 2'b11) &&
                         (is_load_f(mem_op3_in) || is_store_f(mem_op3_in));

`ifdef MEM_ALIGN_TRAP_EN
   assign misalign_s = ((mem_op3_in[1:0] == 2'b00) && (mem_alures_in[1:0] != 2'b00)) ||
                       ((mem_op3_in[1:0] == 2'b10) && mem_alures_in[0]);
`endif

   // Lane offset with the bits a word/halfword access cannot use forced to zero
   always_comb begin
      off_align_s = mem_alures_in[1:0];
      case (mem_op3_in[1:0])
         2'b00:   off_align_s = 2'b00;
         2'b10:   off_align_s = {mem_alures_in[1], 1'b0};
         default: off_align_s = mem_alures_in[1:0];
      endcase
   end

   // Next-state, request capture and writeback decode
   always_comb begin
      state_s    = state_r;
      we_s       = we_r;
      be_s       = be_r;
      addr_s     = addr_r;
      wdata_s    = wdata_r;
      op3_s      = op3_r;
      off_s      = off_r;
      regd_s     = regd_r;
      wb_valid_s = 1'b0;
      wb_en_s    = 1'b0;
      wb_regd_s  = {REG_W{1'b0}};
      wb_data_s  = {DATA_W{1'b0}};
`ifdef MEM_ALIGN_TRAP_EN
      trap_s     = 1'b0;
`endif
      case (state_r)
         IDLE: begin
`ifdef MEM_ALIGN_TRAP_EN
            if (mem_access_s && misalign_s) begin
               wb_valid_s = 1'b1;
               trap_s     = 1'b1;
               wb_regd_s  = mem_regD_in;
               wb_data_s  = mem_alures_in;
            end else
`endif
            if (mem_access_s) begin
               state_s = REQ;
               addr_s  = {mem_alures_in[DATA_W-1:2], 2'b00};
               off_s   = off_align_s;
               be_s    = lane_be_f(mem_op3_in, off_align_s);
               wdata_s = lane_wdata_f(mem_op3_in, mem_stdata_in);
               we_s    = is_store_f(mem_op3_in);
               op3_s   = mem_op3_in;
               regd_s  = mem_regD_in;
            end else begin
               wb_valid_s = 1'b1;
               wb_data_s  = mem_alures_in;
               if (mem_op_in == 2'b01) begin
                  wb_regd_s = CALL_REG;
                  wb_en_s   = 1'b1;
               end else begin
                  wb_regd_s = mem_regD_in;
                  wb_en_s   = (mem_op_in == 2'b10) && (mem_regD_in != {REG_W{1'b0}});
               end
            end
         end
         REQ: begin
            if (dmem.dmem_ready) begin
               if (we_r) begin
                  state_s    = IDLE;
                  wb_valid_s = 1'b1;
                  wb_regd_s  = regd_r;
               end else begin
                  state_s = WAIT;
               end
            end else begin
               state_s = REQ;
            end
         end
         WAIT: begin
            if (dmem.dmem_rvalid) begin
               state_s    = IDLE;
               wb_valid_s = 1'b1;
               wb_en_s    = (regd_r != {REG_W{1'b0}});
               wb_regd_s  = regd_r;
               wb_data_s  = load_extract_f(op3_r, off_r, dmem.dmem_rdata);
            end else begin
               state_s = WAIT;
            end
         end
         default: state_s = IDLE;
      endcase
   end

   // State and output registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_r    <= IDLE;
         stall_r    <= 1'b0;
         req_r      <= 1'b0;
         we_r       <= 1'b0;
         be_r       <= 4'b0000;
         addr_r     <= {DATA_W{1'b0}};
         wdata_r    <= {DATA_W{1'b0}};
         op3_r      <= 6'b000000;
         off_r      <= 2'b00;
         regd_r     <= {REG_W{1'b0}};
         wb_valid_r <= 1'b0;
         wb_en_r    <= 1'b0;
         wb_regd_r  <= {REG_W{1'b0}};
         wb_data_r  <= {DATA_W{1'b0}};
`ifdef MEM_ALIGN_TRAP_EN
         trap_r     <= 1'b0;
`endif
      end else begin
         state_r    <= state_s;
         stall_r    <= (state_s != IDLE);
         req_r      <= (state_s == REQ);
         we_r       <= we_s;
         be_r       <= be_s;
         addr_r     <= addr_s;
         wdata_r    <= wdata_s;
         op3_r      <= op3_s;
         off_r      <= off_s;
         regd_r     <= regd_s;
         wb_valid_r <= wb_valid_s;
         wb_en_r    <= wb_en_s;
         wb_regd_r  <= wb_regd_s;
         wb_data_r  <= wb_data_s;
`ifdef MEM_ALIGN_TRAP_EN
         trap_r     <= trap_s;
`endif
      end
   end

   assign mem_stall        = stall_r;
   assign dmem.dmem_req    = req_r;
   assign dmem.dmem_addr   = addr_r;
   assign dmem.dmem_we     = we_r;
   assign dmem.dmem_be     = be_r;
   assign dmem.dmem_wdata  = wdata_r;
   assign wb_valid         = wb_valid_r;
   assign wb_en            = wb_en_r;
   assign wb_regD          = wb_regd_r;
   assign wb_data          = wb_data_r;
`ifdef MEM_ALIGN_TRAP_EN
   assign mem_trap         = trap_r;
`else
   assign mem_trap         = 1'b0;
`endif

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit. The driver issues EX/MEM instructions,
// plays the data-memory side and pushes the expected writeback into a
// scoreboard queue; a negedge monitor pops and compares on every wb_valid.
module tb_mem_access_unit;

   typedef struct {
      logic        en;
      logic [4:0]  regd;
      logic [31:0] data;
      logic        chk;
      logic        trap;
   } exp_t;

   logic        clk;
   logic        reset;
   logic [4:0]  drv_regd;
   logic [31:0] drv_alures;
   logic [1:0]  drv_op;
   logic [5:0]  drv_op3;
   logic [31:0] drv_stdata;
   logic        mem_stall;
   logic        wb_valid;
   logic        wb_en;
   logic [4:0]  wb_regD;
   logic [31:0] wb_data;
   logic        mem_trap;

   exp_t        sb[$];
   exp_t        mon_e;
   int          n_checks;
   int          n_fail;
   bit          mon_en;

   mem_access_unit_if dmem_if ();

   mem_access_unit dut (
      .clk           (clk),
      .reset         (reset),
      .mem_regD_in   (drv_regd),
      .mem_alures_in (drv_alures),
      .mem_op_in     (drv_op),
      .mem_op3_in    (drv_op3),
      .mem_stdata_in (drv_stdata),
      .mem_stall     (mem_stall),
      .dmem          (dmem_if),
      .wb_valid      (wb_valid),
      .wb_en         (wb_en),
      .wb_regD       (wb_regD),
      .wb_data       (wb_data),
      .mem_trap      (mem_trap)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic push(input logic en, input logic [4:0] regd, input logic [31:0] data,
                       input logic chk, input logic trap);
      exp_t e;
      e.en = en; e.regd = regd; e.data = data; e.chk = chk; e.trap = trap;
      sb.push_back(e);
   endtask

   task automatic set_in(input logic [1:0] op, input logic [5:0] op3, input logic [4:0] regd,
                         input logic [31:0] alures, input logic [31:0] stdata);
      drv_op = op; drv_op3 = op3; drv_regd = regd; drv_alures = alures; drv_stdata = stdata;
   endtask

   task automatic garbage();
      set_in(2'($urandom), 6'($urandom), 5'($urandom), $urandom, $urandom);
   endtask

   // One non-memory instruction; expected writeback given by the caller.
   task automatic nonmem(input logic [1:0] op, input logic [5:0] op3, input logic [4:0] regd,
                         input logic [31:0] alures, input logic e_en, input logic [4:0] e_regd);
      set_in(op, op3, regd, alures, 32'h0);
      push(e_en, e_regd, alures, 1'b1, 1'b0);
      @(posedge clk); #1;
      check("nonmem_stall", mem_stall, 1'b0);
   endtask

   // One load/store; the memory side answers after rdy_dly/rv_dly wait cycles.
   task automatic memop(input logic [5:0] op3, input logic [4:0] regd, input logic [31:0] addr,
                        input logic [31:0] stdata, input int rdy_dly, input int rv_dly,
                        input logic [31:0] rword, input logic [31:0] e_addr, input logic [3:0] e_be,
                        input logic [31:0] e_wdata, input logic [31:0] e_data, input logic e_en,
                        input bit abort);
      logic is_st;
      is_st = op3[2];
      set_in(2'b11, op3, regd, addr, stdata);
      if (!abort) push(e_en, regd, e_data, !is_st, 1'b0);
      @(posedge clk); #1;
      garbage();
      check("req_rise", {mem_stall, dmem_if.dmem_req, dmem_if.dmem_we}, {1'b1, 1'b1, is_st});
      check("dmem_addr", dmem_if.dmem_addr, e_addr);
      check("dmem_be", dmem_if.dmem_be, e_be);
      check("dmem_wdata", dmem_if.dmem_wdata, e_wdata);
      for (int k = 0; k < rdy_dly; k++) begin
         @(posedge clk); #1;
         garbage();
         check("req_hold_ctl", {mem_stall, dmem_if.dmem_req, dmem_if.dmem_we, dmem_if.dmem_be},
               {1'b1, 1'b1, is_st, e_be});
         check("req_hold_data", {dmem_if.dmem_addr, dmem_if.dmem_wdata}, {e_addr, e_wdata});
      end
      dmem_if.dmem_ready  = 1'b1;
      dmem_if.dmem_rvalid = !is_st;
      dmem_if.dmem_rdata  = 32'hDEAD_BEEF;
      @(posedge clk); #1;
      dmem_if.dmem_ready  = 1'b0;
      dmem_if.dmem_rvalid = 1'b0;
      if (is_st) begin
         check("store_done", {mem_stall, dmem_if.dmem_req}, 2'b00);
         return;
      end
      check("wait_state", {mem_stall, dmem_if.dmem_req}, 2'b10);
      if (abort) begin
         reset = 1'b0;
         @(posedge clk); #1;
         check("rst_ctl", {wb_valid, wb_en, wb_regD, mem_stall, dmem_if.dmem_req,
                           dmem_if.dmem_we, dmem_if.dmem_be, mem_trap}, 64'h0);
         check("rst_data", {wb_data, dmem_if.dmem_addr}, 64'h0);
         check("rst_wdata", dmem_if.dmem_wdata, 32'h0);
         reset = 1'b1;
         set_in(2'b00, 6'b000000, 5'd0, 32'h0, 32'h0);
         push(1'b0, 5'd0, 32'h0, 1'b1, 1'b0);
         dmem_if.dmem_rvalid = 1'b1;
         dmem_if.dmem_rdata  = rword;
         @(posedge clk); #1;
         dmem_if.dmem_rvalid = 1'b0;
         check("post_abort", {mem_stall, dmem_if.dmem_req}, 2'b00);
         return;
      end
      for (int k = 0; k < rv_dly; k++) begin
         @(posedge clk); #1;
         garbage();
         check("wait_stall", mem_stall, 1'b1);
      end
      dmem_if.dmem_rvalid = 1'b1;
      dmem_if.dmem_rdata  = rword;
      @(posedge clk); #1;
      dmem_if.dmem_rvalid = 1'b0;
      check("load_done", mem_stall, 1'b0);
   endtask

   // Scoreboard monitor: compare each writeback pulse with the oldest expectation
   always @(negedge clk) begin
      if (mon_en && wb_valid) begin
         if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_wb: got wb_valid=1 data=0x%0h, expected no writeback", wb_data);
         end else begin
            mon_e = sb.pop_front();
            check("wb_en", wb_en, mon_e.en);
            check("mem_trap", mem_trap, mon_e.trap);
            if (mon_e.chk) begin
               check("wb_regD", wb_regD, mon_e.regd);
               check("wb_data", wb_data, mon_e.data);
            end
         end
      end
   end

   initial begin
      n_checks = 0;
      n_fail   = 0;
      mon_en   = 1'b1;
      reset    = 1'b0;
      set_in(2'b00, 6'b000000, 5'd0, 32'h0, 32'h0);
      dmem_if.dmem_ready  = 1'b0;
      dmem_if.dmem_rvalid = 1'b0;
      dmem_if.dmem_rdata  = 32'h0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_ctl", {wb_valid, wb_en, wb_regD, mem_stall, dmem_if.dmem_req,
                          dmem_if.dmem_we, dmem_if.dmem_be, mem_trap}, 64'h0);
      check("reset_data", {wb_data, dmem_if.dmem_addr}, 64'h0);
      reset = 1'b1;

      // Non-memory pass-through
      nonmem(2'b10, 6'b000000, 5'd3, 32'h0000_1234, 1'b1, 5'd3);
      nonmem(2'b10, 6'b000010, 5'd0, 32'h0000_00AA, 1'b0, 5'd0);
      nonmem(2'b01, 6'b000000, 5'd7, 32'h0000_0400, 1'b1, 5'd15);
      nonmem(2'b00, 6'b000100, 5'd5, 32'h0001_0000, 1'b0, 5'd5);
      nonmem(2'b11, 6'b111111, 5'd4, 32'h0000_0055, 1'b0, 5'd4);

      // Loads and stores: op3, rd, addr, stdata, rdy, rv, rword, addr, be, wdata, data, en, abort
      memop(6'b001001, 5'd1, 32'h0000_0101, 32'h0, 2, 0, 32'h11F2_3344,
            32'h0000_0100, 4'b0100, 32'h0, 32'hFFFF_FFF2, 1'b1, 1'b0);
      memop(6'b000110, 5'd2, 32'h0000_0202, 32'h0000_ABCD, 0, 0, 32'h0,
            32'h0000_0200, 4'b0011, 32'hABCD_ABCD, 32'h0, 1'b0, 1'b0);
      memop(6'b000000, 5'd9, 32'h0000_0300, 32'h0, 5, 2, 32'h89AB_CDEF,
            32'h0000_0300, 4'b1111, 32'h0, 32'h89AB_CDEF, 1'b1, 1'b0);
      memop(6'b000001, 5'd10, 32'h0000_0103, 32'h0, 1, 1, 32'h11F2_3344,
            32'h0000_0100, 4'b0001, 32'h0, 32'h0000_0044, 1'b1, 1'b0);
      memop(6'b001010, 5'd6, 32'h0000_0102, 32'h0, 0, 0, 32'h1122_8001,
            32'h0000_0100, 4'b0011, 32'h0, 32'hFFFF_8001, 1'b1, 1'b0);
      memop(6'b000010, 5'd11, 32'h0000_0100, 32'h0, 0, 1, 32'h8001_1122,
            32'h0000_0100, 4'b1100, 32'h0, 32'h0000_8001, 1'b1, 1'b0);
      memop(6'b000101, 5'd12, 32'h0000_0401, 32'h1234_565A, 1, 0, 32'h0,
            32'h0000_0400, 4'b0100, 32'h5A5A_5A5A, 32'h0, 1'b0, 1'b0);
      memop(6'b000100, 5'd13, 32'h0000_0500, 32'hCAFE_F00D, 0, 0, 32'h0,
            32'h0000_0500, 4'b1111, 32'hCAFE_F00D, 32'h0, 1'b0, 1'b0);
      memop(6'b000000, 5'd0, 32'h0000_0700, 32'h0, 0, 0, 32'h7777_0001,
            32'h0000_0700, 4'b1111, 32'h0, 32'h7777_0001, 1'b0, 1'b0);
      nonmem(2'b10, 6'b000000, 5'd20, 32'hFFFF_0000, 1'b1, 5'd20);

      // Misaligned word load
`ifdef MEM_ALIGN_TRAP_EN
      set_in(2'b11, 6'b000000, 5'd2, 32'h0000_0102, 32'h0);
      push(1'b0, 5'd2, 32'h0, 1'b0, 1'b1);
      @(posedge clk); #1;
      check("trap_no_req", {mem_stall, dmem_if.dmem_req}, 2'b00);
`else
      memop(6'b000000, 5'd2, 32'h0000_0102, 32'h0, 0, 0, 32'h0BAD_F00D,
            32'h0000_0100, 4'b1111, 32'h0, 32'h0BAD_F00D, 1'b1, 1'b0);
`endif

      // Reset while waiting for read data abandons the load
      memop(6'b000000, 5'd8, 32'h0000_0600, 32'h0, 1, 0, 32'h1234_5678,
            32'h0000_0600, 4'b1111, 32'h0, 32'h0, 1'b0, 1'b1);
      nonmem(2'b10, 6'b000000, 5'd21, 32'h0000_0BEE, 1'b1, 5'd21);

      @(negedge clk); #1;
      mon_en = 1'b0;
      check("sb_drained", sb.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
